uart_cmd_assembler: RTL and testbench

Host-side front end of the command path: gathers three consecutive bytes from the UART receiver into one 24-bit command. It presents that command to the command processor with a `cmd_rdy`/`clr_cmd_rdy` handshake. It also relays the processor's one-byte responses (`send_resp`/`resp_data`) to the UART transmitter and returns `resp_sent` when each byte has left the wire.

---
 rtl/uart_cmd_assembler.sv | 150 +++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// UART command front end: packs three RX bytes into a 24-bit command
// and relays one-byte responses to the UART transmitter.
module uart_cmd_assembler #(
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp_data,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        frame_err
);

  typedef enum logic [1:0] {HIGH, MID, LOW, HOLD} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [7:0]      hi, mid;
  logic [TO_W-1:0] cnt;
  logic            accept, timeout;
  logic            busy, pend_vld;
  logic [7:0]      pend;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      HIGH: begin
        if (rx_rdy) begin
          accept    = 1'b1;
          state_nxt = MID;
        end
      end
      MID: begin
        if (rx_rdy) begin
          accept    = 1'b1;
          state_nxt = LOW;
        end else if (cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = HIGH;
        end
      end
      LOW: begin
        if (rx_rdy) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end else if (cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HOLD: begin
        if (clr_cmd_rdy)
          state_nxt = HIGH;
      end
      default: state_nxt = HIGH;
    endcase
  end

  // Held low during reset so a waiting RX byte is not consumed.
  assign clr_rx_rdy = accept & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= HIGH;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi        <= '0;
      mid       <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout;
      if (accept && state == HIGH)
        hi <= rx_data;
      if (accept && state == MID)
        mid <= rx_data;
      if (accept && state == LOW) begin
        cmd     <= {hi, mid, rx_data};
        cmd_rdy <= 1'b1;
      end
      if (state == HOLD && clr_cmd_rdy)
        cmd_rdy <= 1'b0;
      if (timeout) begin
        hi  <= '0;
        mid <= '0;
      end
      if ((state == MID || state == LOW) && !rx_rdy && !timeout)
        cnt <= cnt + TO_W'(1);
      else
        cnt <= '0;
    end
  end

  // Response path: one byte in flight plus a single pending slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      pend_vld  <= 1'b0;
      pend      <= '0;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      if (tx_done && busy) begin
        resp_sent <= 1'b1;
        if (pend_vld) begin
          tx_data  <= pend;
          trmt     <= 1'b1;
          pend_vld <= 1'b0;
        end else if (send_resp) begin
          tx_data <= resp_data;
          trmt    <= 1'b1;
        end else begin
          busy <= 1'b0;
        end
      end else if (send_resp) begin
        if (!busy) begin
          tx_data <= resp_data;
          trmt    <= 1'b1;
          busy    <= 1'b1;
        end else if (!pend_vld) begin
          pend     <= resp_data;
          pend_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench for uart_cmd_assembler: queue-level reference model
// predicts output events; a monitor matches them against the DUT.
module tb_uart_cmd_assembler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        resp_sent;
  logic        frame_err;

  uart_cmd_assembler #(.TIMEOUT(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp_data(resp_data),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .resp_sent(resp_sent), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string n, longint a, longint e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  // reference model state
  logic [7:0]  m_frame[$];
  logic [7:0]  oq[$];
  bit          m_hold = 0;
  int          idle = 0;
  int          done_at = -100;
  int          tx_dly = 3;
  bit          have = 0;
  logic [7:0]  cur = 8'h00;

  // expected events
  int          acc_q[$], rise_q[$], fall_q[$], fe_q[$], trmt_q[$], rs_q[$];
  logic [23:0] cmd_q[$];
  logic [7:0]  txd_q[$];

  task automatic model_step(int c);
    int  pre;
    bit  done;
    if (m_hold) begin
      if (clr_cmd_rdy) begin
        m_hold = 0;
        fall_q.push_back(c + 1);
      end
    end else if (rx_rdy) begin
      acc_q.push_back(c);
      m_frame.push_back(rx_data);
      have = 0;
      idle = 0;
      if (m_frame.size() == 3) begin
        cmd_q.push_back({m_frame[0], m_frame[1], m_frame[2]});
        rise_q.push_back(c + 1);
        m_frame.delete();
        m_hold = 1;
      end
    end else if (m_frame.size() > 0) begin
      idle++;
      if (idle == TO) begin
        m_frame.delete();
        idle = 0;
        fe_q.push_back(c + 1);
      end
    end
    pre  = oq.size();
    done = tx_done && pre > 0;
    if (done) begin
      void'(oq.pop_front());
      rs_q.push_back(c + 1);
    end
    if (send_resp && pre < 2)
      oq.push_back(resp_data);
    if (oq.size() > 0 && (done || pre == 0)) begin
      trmt_q.push_back(c + 1);
      txd_q.push_back(oq[0]);
      done_at = c + 1 + tx_dly;
    end
  endtask

  task automatic tick(input bit nb, input logic [7:0] b, input bit clr,
                      input bit snd, input logic [7:0] sd);
    @(negedge clk);
    if (nb && !have) begin
      have = 1;
      cur  = b;
    end
    rx_rdy      = have;
    rx_data     = have ? cur : 8'h00;
    clr_cmd_rdy = clr;
    send_resp   = snd;
    resp_data   = sd;
    tx_done     = (cyc == done_at);
    model_step(cyc);
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 0, 8'h00);
  endtask

  task automatic byte_in(logic [7:0] b);
    tick(1, b, 0, 0, 8'h00);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_cmd"}, cmd, 0);
    chk({tag, "_cmd_rdy"}, cmd_rdy, 0);
    chk({tag, "_clr_rx_rdy"}, clr_rx_rdy, 0);
    chk({tag, "_trmt"}, trmt, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_resp_sent"}, resp_sent, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_rdy = 0; clr_cmd_rdy = 0; send_resp = 0; tx_done = 0;
    have = 0;
    #1;
    chk_zero("rst");
    m_frame.delete(); oq.delete();
    m_hold = 0; idle = 0;
    acc_q.delete(); rise_q.delete(); fall_q.delete(); fe_q.delete();
    trmt_q.delete(); rs_q.delete(); cmd_q.delete(); txd_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: pops expected events whenever the DUT presents one
  logic [23:0] last_cmd = 24'h0;
  bit          prev_rdy = 0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        last_cmd = 24'h0;
        prev_rdy = 0;
      end else begin
        if (clr_rx_rdy)
          chk("accept_cyc", cyc, acc_q.size() ? acc_q.pop_front() : -1);
        if (cmd_rdy && !prev_rdy) begin
          chk("cmd_rdy_rise", cyc, rise_q.size() ? rise_q.pop_front() : -1);
          if (cmd_q.size()) last_cmd = cmd_q.pop_front();
          else chk("cmd_unexpected", cmd, -1);
        end
        if (!cmd_rdy && prev_rdy)
          chk("cmd_rdy_fall", cyc, fall_q.size() ? fall_q.pop_front() : -1);
        chk("cmd_value", cmd, last_cmd);
        if (frame_err)
          chk("frame_err_cyc", cyc, fe_q.size() ? fe_q.pop_front() : -1);
        if (trmt) begin
          chk("trmt_cyc", cyc, trmt_q.size() ? trmt_q.pop_front() : -1);
          chk("tx_data", tx_data, txd_q.size() ? txd_q.pop_front() : -1);
        end
        if (resp_sent)
          chk("resp_sent_cyc", cyc, rs_q.size() ? rs_q.pop_front() : -1);
        prev_rdy = cmd_rdy;
      end
    end
  end

  initial begin
    int rate;
    #3;
    chk_zero("init");
    @(negedge clk);
    rst = 1'b0;

    // frame 02 0D 55, one byte per 10 cycles
    byte_in(8'h02); idle_n(9);
    byte_in(8'h0D); idle_n(9);
    byte_in(8'h55); idle_n(4);
    // 0x07 waits while the command is held
    byte_in(8'h07); idle_n(5);
    tick(0, 8'h00, 1, 0, 8'h00);
    idle_n(2);
    byte_in(8'h33); byte_in(8'h44); idle_n(2);
    tick(0, 8'h00, 1, 0, 8'h00);
    // partial frame times out after 16 idle cycles
    byte_in(8'h03); byte_in(8'h80); idle_n(20);
    // third byte on the last allowed cycle
    byte_in(8'hA1); byte_in(8'hB2); idle_n(TO - 1);
    byte_in(8'hC3); idle_n(2);
    tick(0, 8'h00, 1, 0, 8'h00);
    // responses: third one dropped while pending is full
    tx_dly = 6;
    tick(0, 8'h00, 0, 1, 8'hA5);
    tick(0, 8'h00, 0, 1, 8'hEE);
    tick(0, 8'h00, 0, 1, 8'h11);
    idle_n(16);
    // reset mid-frame with a byte in flight
    tick(0, 8'h00, 0, 1, 8'h3C);
    byte_in(8'h12); byte_in(8'h34);
    do_reset();
    idle_n(6);
    byte_in(8'h9A); byte_in(8'hBC); byte_in(8'hDE); idle_n(2);
    tick(0, 8'h00, 1, 0, 8'h00);

    // randomized traffic
    rate = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 2;
          1: rate = 6;
          default: rate = 40;
        endcase
      end
      tx_dly = $urandom_range(1, 8);
      tick(($urandom % rate) == 0, 8'($urandom),
           m_hold ? ($urandom % 5 == 0) : ($urandom % 20 == 0),
           ($urandom % 6) == 0, 8'($urandom));
    end
    idle_n(TO + 40);
    @(negedge clk);
    #3;
    chk("leftover_events",
        acc_q.size() + rise_q.size() + fall_q.size() + fe_q.size() +
        trmt_q.size() + rs_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
